// File: rtl/ghost_mode_scheduler_pkg.sv
// Shared mode definitions and the level-1 scatter/chase schedule used by
// the mode scheduler and every ghost module.
package ghost_mode_pkg;

    localparam int FRAME_HZ   = 60;
    localparam int PHASE_W    = 12;
    localparam int IDX_W      = 3;
    localparam int LAST_PHASE = 7;

    typedef enum logic [1:0] {
        MODE_IDLE,
        MODE_SCATTER,
        MODE_CHASE,
        MODE_FRIGHT
    } mode_e;

    localparam logic [PHASE_W-1:0] SCATTER_LONG  = 12'd420;
    localparam logic [PHASE_W-1:0] SCATTER_SHORT = 12'd300;
    localparam logic [PHASE_W-1:0] CHASE_LEN     = 12'd1200;

    // Phase 7 returns 0: it is the endless final chase and never counts down.
    function automatic logic [PHASE_W-1:0] phase_duration(input logic [IDX_W-1:0] idx);
        case (idx)
            3'd0, 3'd2:       phase_duration = SCATTER_LONG;
            3'd1, 3'd3, 3'd5: phase_duration = CHASE_LEN;
            3'd4, 3'd6:       phase_duration = SCATTER_SHORT;
            default:          phase_duration = '0;
        endcase
    endfunction

endpackage

// File: rtl/ghost_mode_scheduler_if.sv
// Control/status bundle between the game controller (master) and the
// ghost mode scheduler (slave).
interface ghost_mode_scheduler_if;
    import ghost_mode_pkg::*;

    logic             frameTick;
    logic             start;
    logic             pause;
    logic             powerPellet;
    logic             isScatter;
    logic             isChase;
    logic             isFrightened;
    logic             frightFlash;
    logic             reverseReq;
    logic [IDX_W-1:0] phaseIdx;

    modport master (
        output frameTick, start, pause, powerPellet,
        input  isScatter, isChase, isFrightened, frightFlash, reverseReq, phaseIdx
    );

    modport slave (
        input  frameTick, start, pause, powerPellet,
        output isScatter, isChase, isFrightened, frightFlash, reverseReq, phaseIdx
    );
endinterface

// File: rtl/ghost_mode_scheduler.sv
// Global scatter/chase/frightened sequencer shared by all four ghosts,
// advanced by qualified 60 Hz frame ticks.
module ghost_mode_scheduler
    import ghost_mode_pkg::*;
#(
    parameter int FRIGHT_FRAMES = 360,
    parameter int FLASH_FRAMES  = 120
) (
    input  logic                  clk,
    input  logic                  reset_n,
    ghost_mode_scheduler_if.slave bus
);

    localparam int                  FRIGHT_W    = 9;
    localparam logic [FRIGHT_W-1:0] FRIGHT_LOAD = FRIGHT_W'(FRIGHT_FRAMES);
    localparam logic [FRIGHT_W-1:0] FLASH_LEVEL = FRIGHT_W'(FLASH_FRAMES);

    mode_e               r_state,      w_state_nxt;
    logic [IDX_W-1:0]    r_phase_idx,  w_phase_idx_nxt;
    logic [PHASE_W-1:0]  r_phase_cnt,  w_phase_cnt_nxt;
    logic [FRIGHT_W-1:0] r_fright_cnt, w_fright_cnt_nxt;
    logic                w_reverse_nxt;

    logic r_is_scatter, r_is_chase, r_is_frightened, r_fright_flash, r_reverse_req;

    logic             w_active, w_run, w_pellet;
    logic [IDX_W-1:0] w_idx_inc;

    assign w_active  = bus.start & ~bus.pause;
    assign w_run     = w_active & bus.frameTick;
    assign w_pellet  = w_active & bus.powerPellet;
    assign w_idx_inc = r_phase_idx + 1'b1;

    always_comb begin
        // NOTE: every next value starts from its hold value so no branch can infer a latch.
        w_state_nxt      = r_state;
        w_phase_idx_nxt  = r_phase_idx;
        w_phase_cnt_nxt  = r_phase_cnt;
        w_fright_cnt_nxt = r_fright_cnt;
        w_reverse_nxt    = 1'b0;

        if (!bus.start) begin
            w_state_nxt      = MODE_IDLE;
            w_phase_idx_nxt  = '0;
            w_phase_cnt_nxt  = '0;
            w_fright_cnt_nxt = '0;
        end else if (!bus.pause) begin
            case (r_state)
                MODE_IDLE: begin
                    w_state_nxt     = MODE_SCATTER;
                    w_phase_idx_nxt = '0;
                    w_phase_cnt_nxt = phase_duration('0);
                end
                MODE_SCATTER, MODE_CHASE: begin
                    if (w_run && r_phase_idx != IDX_W'(LAST_PHASE)) begin
                        if (r_phase_cnt == PHASE_W'(1)) begin
                            w_phase_idx_nxt = w_idx_inc;
                            w_phase_cnt_nxt = phase_duration(w_idx_inc);
                            w_state_nxt     = w_idx_inc[0] ? MODE_CHASE : MODE_SCATTER;
                            w_reverse_nxt   = 1'b1;
                        end else begin
                            w_phase_cnt_nxt = r_phase_cnt - 1'b1;
                        end
                    end
                    // A pellet on the expiry tick still advances the phase; one reverse covers both.
                    if (w_pellet) begin
                        w_state_nxt      = MODE_FRIGHT;
                        w_fright_cnt_nxt = FRIGHT_LOAD;
                        w_reverse_nxt    = 1'b1;
                    end
                end
                MODE_FRIGHT: begin
                    if (w_pellet) begin
                        w_fright_cnt_nxt = FRIGHT_LOAD;
                    end else if (w_run) begin
                        w_fright_cnt_nxt = r_fright_cnt - 1'b1;
                        if (r_fright_cnt == FRIGHT_W'(1)) begin
                            w_state_nxt = r_phase_idx[0] ? MODE_CHASE : MODE_SCATTER;
                        end
                    end
                end
                default: w_state_nxt = MODE_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= MODE_IDLE;
            r_phase_idx     <= '0;
            r_phase_cnt     <= '0;
            r_fright_cnt    <= '0;
            r_is_scatter    <= 1'b0;
            r_is_chase      <= 1'b0;
            r_is_frightened <= 1'b0;
            r_fright_flash  <= 1'b0;
            r_reverse_req   <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_phase_idx     <= w_phase_idx_nxt;
            r_phase_cnt     <= w_phase_cnt_nxt;
            r_fright_cnt    <= w_fright_cnt_nxt;
            r_is_scatter    <= (w_state_nxt == MODE_SCATTER);
            r_is_chase      <= (w_state_nxt == MODE_CHASE);
            r_is_frightened <= (w_state_nxt == MODE_FRIGHT);
            r_fright_flash  <= (w_state_nxt == MODE_FRIGHT) && (w_fright_cnt_nxt <= FLASH_LEVEL);
            r_reverse_req   <= w_reverse_nxt;
        end
    end

    assign bus.isScatter    = r_is_scatter;
    assign bus.isChase      = r_is_chase;
    assign bus.isFrightened = r_is_frightened;
    assign bus.frightFlash  = r_fright_flash;
    assign bus.reverseReq   = r_reverse_req;
    assign bus.phaseIdx     = r_phase_idx;

endmodule

// File: doc/ghost_mode_scheduler.md
# ghost_mode_scheduler

Global mode sequencer for all four ghosts. Counts 60 Hz frame ticks through the level-1 scatter/chase schedule and overrides it with frightened mode on power-pellet events. Drives the `isChase`/`isScatter` inputs of every ghost module and issues a one-cycle direction-reverse request on each mode change. One instance sits in the top-level game controller, fed by the shared frame-tick generator.

## Interface

Parameters:
- `FRIGHT_FRAMES`, default 360: frightened duration in frame ticks (6 s).
- `FLASH_FRAMES`, default 120: final frightened ticks with `frightFlash` asserted (2 s).

Ports:
- `clk`, in, 1: system clock (25 MHz).
- `reset_n`, in, 1: asynchronous, active-low reset.
- `frameTick`, in, 1: one-cycle pulse at 60 Hz.
- `start`, in, 1: level, game running (ghost start delay elapsed).
- `pause`, in, 1: level, freezes all counting.
- `powerPellet`, in, 1: one-cycle pulse when Pac-Man eats an energizer.
- `isScatter`, out, 1: scatter mode active.
- `isChase`, out, 1: chase mode active.
- `isFrightened`, out, 1: frightened mode active.
- `frightFlash`, out, 1: frightened and remaining count ≤ `FLASH_FRAMES`.
- `reverseReq`, out, 1: one-cycle pulse; ghosts reverse direction.
- `phaseIdx`, out, 3: current schedule phase (0..7).

## Operation

- **States:** IDLE, SCATTER, CHASE, FRIGHT. All outputs are registered.
- **Qualified tick:** `run = start & ~pause & frameTick`. Counters change only on `run`.
- **Schedule:** durations in ticks, by phase 0..7, are 420, 1200, 420, 1200, 300, 1200, 300, infinite.
  - Even phases are scatter; odd phases are chase.
  - Phase 7 never expires and `phaseIdx` saturates at 7.
- **IDLE:**
  - Outputs are 0 and `phaseIdx` = 0.
  - When `start` = 1, go to SCATTER and load `phaseCnt` = 420. No `reverseReq`.
- **SCATTER/CHASE:**
  - Each `run` decrements `phaseCnt` (12 bits).
  - On a `run` with `phaseCnt` == 1: increment `phaseIdx`, load the next duration, switch SCATTER↔CHASE, and pulse `reverseReq`.
- **Entering FRIGHT:**
  - A `powerPellet` received while `start & ~pause` (in SCATTER or CHASE) enters FRIGHT.
  - Load `frightCnt` = `FRIGHT_FRAMES` (9 bits) and pulse `reverseReq`.
  - `phaseCnt` holds for the whole of FRIGHT.
- **In FRIGHT:**
  - Each `run` decrements `frightCnt`.
  - A further `powerPellet` reloads `frightCnt` and produces no `reverseReq`.
  - When `frightCnt` == 1 on a `run`, return to SCATTER if `phaseIdx` is even, otherwise CHASE. No `reverseReq`.
- **Outputs:**
  - `isScatter`/`isChase` are 0 during FRIGHT; `isFrightened` = 1.
  - `frightFlash` = FRIGHT & (`frightCnt` ≤ `FLASH_FRAMES`).
- **`start` deasserted in any state:** return to IDLE next cycle, clearing `phaseIdx` and the counters.
- **Pause:** `pause` freezes state and counters. `powerPellet` is ignored while paused or in IDLE.

## Timing

- Reset (asynchronous assert, synchronous release): state IDLE, all outputs 0, `phaseIdx` = 0, counters 0.
- Latency: an output changes on the clock edge after the input cycle that caused it (1 cycle).
- `reverseReq` is high for exactly one clock per event.
- A phase lasts exactly its duration in qualified ticks. Likewise, fright lasts exactly `FRIGHT_FRAMES` ticks after the last pellet.
- **Simultaneous phase expiry and `powerPellet`:**
  - The phase advances (`phaseIdx`+1, next duration loaded).
  - FRIGHT is entered.
  - Exactly one `reverseReq` is issued.
- **Simultaneous `powerPellet` and fright expiry:** stay in FRIGHT with `frightCnt` reloaded.
- `reset_n` asserted mid-fright or mid-phase: immediate IDLE, no `reverseReq`.

## Structure

- Package `ghost_mode_pkg` holds:
  - the mode enum (IDLE, SCATTER, CHASE, FRIGHT);
  - the phase-duration constants and a `phase_duration(idx)` function;
  - the `FRAME_HZ` = 60 constant.
  All ghost modules import it.
- No sub-module is needed inside this block. `frameTick` comes from the shared `frame_tick_gen` (divide by 416_667), which replaces the per-ghost dividers.

## Test plan

- Reset, then `start` = 1 and continuous `frameTick` every 4 clocks:
  - `isScatter` = 1 and `phaseIdx` = 0 for 420 ticks;
  - after tick 420: `isChase` = 1, `phaseIdx` = 1, one `reverseReq`.
- Run 5040 ticks: reaches phase 7 chase. Run 5000 more: stays chase, `phaseIdx` = 7, no `reverseReq`.
- `powerPellet` at tick 100 of phase 1:
  - `isFrightened` = 1 with one `reverseReq`;
  - `frightFlash` rises after 240 ticks;
  - chase resumes after 360 ticks, with phase 1 expiring 1100 ticks later.
- Second `powerPellet` 200 ticks into fright: FRIGHT is extended to 560 ticks total, with only one `reverseReq` overall.
- `pause` = 1 for 1000 ticks mid-scatter, with `powerPellet` pulsed: no state or count change and the pellet is ignored.
- `powerPellet` on the expiry tick of phase 0: `phaseIdx` = 1, FRIGHT entered, single `reverseReq`. Then `reset_n` low mid-fright: all outputs 0 asynchronously.
